// File: rtl/exp_engine_arbiter.sv
// exp_engine_arbiter: round-robin sharing of one a^n engine between two
// requesters. Latches the winner's operands, pulses the engine start, waits
// for an armed done (or a watchdog timeout) and strobes the result back to
// the requester that owns the operation.
//
// Handshake: a requester raises req_i[r] and holds it together with its
// operands until res_valid_o[r] pulses for one cycle; that pulse is the
// only completion indication. gnt_o shows ownership from GRANT through
// RESP. Towards the engine, eng_go_o is a one-cycle start and eng_done_i is
// a level that is only trusted after it has been seen low inside WAIT.
module exp_engine_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [7:0]  a0_i,
  input  logic [7:0]  n0_i,
  input  logic [7:0]  a1_i,
  input  logic [7:0]  n1_i,
  output logic [1:0]  gnt_o,
  output logic [15:0] res_o,
  output logic [1:0]  res_valid_o,
  output logic        err_o,
  output logic        eng_go_o,
  output logic [7:0]  eng_a_o,
  output logic [7:0]  eng_n_o,
  input  logic        eng_done_i,
  input  logic [15:0] eng_result_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;   // index of the most recent winner
  logic        arm_q, arm_d;     // done has been seen low in this operation
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic        err_q, err_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  n_q, n_d;
  logic        win;

  // Winner: a lone request wins outright; with both pending the one that
  // was not served last goes next.
  always_comb begin
    win = req_i[1];
    if (req_i == 2'b11) begin
      win = ~last_q;
    end
  end

  // Next-state and datapath updates for the four-phase sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    a_d     = a_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_GRANT;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          a_d     = win ? a1_i : a0_i;
          n_d     = win ? n1_i : n0_i;
        end
      end
      S_GRANT: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
        arm_d   = 1'b0;
      end
      S_WAIT: begin
        if (arm_q && eng_done_i) begin
          res_d   = eng_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          res_d   = 16'hFFFF;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          arm_d = arm_q | ~eng_done_i;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      arm_q   <= 1'b0;
      cnt_q   <= 16'd0;
      res_q   <= 16'd0;
      err_q   <= 1'b0;
      a_q     <= 8'd0;
      n_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      a_q     <= a_d;
      n_q     <= n_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign res_o       = res_q;
  assign res_valid_o = (state_q == S_RESP) ? gnt_q : 2'b00;
  assign err_o       = (state_q == S_RESP) & err_q;
  assign eng_go_o    = (state_q == S_GRANT);
  assign eng_a_o     = a_q;
  assign eng_n_o     = n_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Bench for exp_engine_arbiter: behavioural engine, scoreboard of expected
// strobes {res_valid, res, err}, and directed scenarios for arbitration,
// stale done, watchdog timeout and reset during an operation.
module tb_exp_engine_arbiter;

  localparam int TMO = 20;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [7:0]  a0_i, n0_i, a1_i, n1_i;
  logic [1:0]  gnt_o;
  logic [15:0] res_o;
  logic [1:0]  res_valid_o;
  logic        err_o;
  logic        eng_go_o;
  logic [7:0]  eng_a_o, eng_n_o;
  logic        eng_done_i;
  logic [15:0] eng_result_i;
  logic [1:0]  state_o;

  exp_engine_arbiter #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .a0_i         (a0_i),
    .n0_i         (n0_i),
    .a1_i         (a1_i),
    .n1_i         (n1_i),
    .gnt_o        (gnt_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .err_o        (err_o),
    .eng_go_o     (eng_go_o),
    .eng_a_o      (eng_a_o),
    .eng_n_o      (eng_n_o),
    .eng_done_i   (eng_done_i),
    .eng_result_i (eng_result_i),
    .state_o      (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  logic [18:0] e_mon;
  int cyc = 0;
  int go_count = 0;
  int go_cyc = 0;
  int resp_cyc = 0;
  int strobe_count = 0;

  // engine model controls
  int   eng_lat = 4;
  bit   stale_mode = 1'b0;
  bit   never_mode = 1'b0;
  bit   busy = 1'b0;
  int   left = 0;
  logic [15:0] val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pow16(input logic [7:0] a, input logic [7:0] n);
    logic [15:0] p;
    p = 16'd1;
    for (int i = 0; i < int'(n); i++) p = p * {8'd0, a};
    return p;
  endfunction

  // behavioural engine: done is a level, result valid while done is high
  initial begin
    eng_done_i   = 1'b0;
    eng_result_i = 16'd0;
    forever begin
      @(negedge clk);
      if (eng_go_o) begin
        busy = !never_mode;
        left = eng_lat;
        val  = pow16(eng_a_o, eng_n_o);
        if (!stale_mode) eng_done_i = 1'b0;
      end else if (busy) begin
        left--;
        if (left == 0) begin
          eng_done_i   = 1'b1;
          eng_result_i = val;
          busy         = 1'b0;
        end else if (stale_mode && left == 1) begin
          eng_done_i = 1'b0;
        end
      end
    end
  end

  // monitor and scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (eng_go_o) begin
        go_count++;
        go_cyc = cyc;
      end
      if (res_valid_o != 2'b00) begin
        resp_cyc = cyc;
        strobe_count++;
        if (exp_q.size() == 0) begin
          check_eq("strobe_unexpected", {62'd0, res_valid_o}, 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check_eq("strobe", {45'd0, res_valid_o, res_o, err_o}, {45'd0, e_mon});
          check_eq("strobe_gnt", {62'd0, res_valid_o}, {62'd0, gnt_o});
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] n,
                       input logic [15:0] res, input bit err);
    if (r == 0) begin
      a0_i = a; n0_i = n;
    end else begin
      a1_i = a; n1_i = n;
    end
    req_i[r] = 1'b1;
    exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, res, err});
  endtask

  task automatic wait_go(output int c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (eng_go_o) seen = 1'b1;
    end
    check_eq("go_seen", {63'd0, seen}, 64'd1);
    c = go_cyc;
  endtask

  task automatic wait_strobe(output int c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (res_valid_o != 2'b00) seen = 1'b1;
    end
    check_eq("strobe_seen", {63'd0, seen}, 64'd1);
    c = resp_cyc;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int gc, sc, g0, s0;
    rst = 1'b1; req_i = 2'b00;
    a0_i = 8'd0; n0_i = 8'd0; a1_i = 8'd0; n1_i = 8'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs", {26'd0, gnt_o, res_o, res_valid_o, err_o, eng_go_o,
                               eng_a_o, eng_n_o, state_o}, 64'd0);
    rst = 1'b1;

    // single request, done 10 cycles after go
    @(negedge clk); #1;
    eng_lat = 10;
    g0 = go_count;
    issue(0, 8'd3, 8'd4, 16'd81, 1'b0);
    wait_go(gc);
    check_eq("t1_gnt", {62'd0, gnt_o}, 64'd1);
    check_eq("t1_operands", {48'd0, eng_a_o, eng_n_o}, {48'd0, 8'd3, 8'd4});
    wait_strobe(sc);
    req_i[0] = 1'b0;
    check_eq("t1_go_count", go_count - g0, 1);
    check_eq("t1_latency", sc - gc, 11);

    // simultaneous requests straight after reset
    do_reset();
    @(negedge clk); #1;
    eng_lat = $urandom_range(3, 8);
    issue(0, 8'd5, 8'd5, 16'd3125, 1'b0);
    issue(1, 8'd9, 8'd4, 16'd6561, 1'b0);
    wait_go(gc);
    check_eq("t2_first_gnt", {62'd0, gnt_o}, 64'd1);
    wait_strobe(sc);
    req_i[0] = 1'b0;
    eng_lat = $urandom_range(3, 8);
    wait_go(gc);
    check_eq("t2_gap", gc - sc, 2);
    check_eq("t2_second_gnt", {62'd0, gnt_o}, 64'd2);
    check_eq("t2_operands", {48'd0, eng_a_o, eng_n_o}, {48'd0, 8'd9, 8'd4});
    wait_strobe(sc);
    req_i[1] = 1'b0;

    // fairness: both held for six operations
    @(negedge clk); #1;
    eng_lat = $urandom_range(2, 12);
    for (int k = 0; k < 3; k++) begin
      issue(0, 8'd7, 8'd5, 16'd16807, 1'b0);
      issue(1, 8'd13, 8'd3, 16'd2197, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      wait_strobe(sc);
      eng_lat = $urandom_range(2, 12);
    end
    req_i = 2'b00;

    // watchdog timeout
    @(negedge clk); #1;
    never_mode = 1'b1;
    issue(1, 8'd2, 8'd15, 16'hFFFF, 1'b1);
    wait_go(gc);
    wait_strobe(sc);
    req_i[1] = 1'b0;
    never_mode = 1'b0;
    check_eq("t4_latency", sc - gc, TMO + 1);

    // normal operation after timeout; leaves done high with result 8
    @(negedge clk); #1;
    eng_lat = 4;
    issue(0, 8'd2, 8'd3, 16'd8, 1'b0);
    wait_strobe(sc);
    req_i[0] = 1'b0;

    // stale done from the previous operation
    @(negedge clk); #1;
    stale_mode = 1'b1;
    eng_lat = 5;
    issue(1, 8'd11, 8'd4, 16'd14641, 1'b0);
    wait_go(gc);
    wait_strobe(sc);
    req_i[1] = 1'b0;
    stale_mode = 1'b0;
    check_eq("t5_latency", sc - gc, 6);

    // reset during WAIT aborts without a strobe
    @(negedge clk); #1;
    eng_lat = 15;
    a0_i = 8'd2; n0_i = 8'd5;
    req_i[0] = 1'b1;
    s0 = strobe_count;
    wait_go(gc);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_async_clear", {26'd0, gnt_o, res_o, res_valid_o, err_o, eng_go_o,
                                eng_a_o, eng_n_o, state_o}, 64'd0);
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t6_no_strobe", strobe_count - s0, 0);
    eng_lat = 6;
    issue(0, 8'd2, 8'd14, 16'd16384, 1'b0);
    wait_go(gc);
    wait_strobe(sc);
    req_i[0] = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
